// File: rtl/random_choose_arbiter.sv
// random_choose_arbiter: round-robin sharing of one weighted-segment chooser among several requesters.
module random_choose #(
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                      in_clock,
  input  logic                      in_reset,
  input  logic [7:0]                in_seed,
  input  logic                      in_enable,
  input  logic [4*WEIGHT_WIDTH-1:0] in_weights,
  output logic [1:0]                out_segment_number
);
  localparam int SW = WEIGHT_WIDTH + 2;
  logic [7:0]    lfsr;
  logic [SW-1:0] c0, c1, c2, c3, r;
  assign c0 = SW'(in_weights[0 +: WEIGHT_WIDTH]);
  assign c1 = c0 + SW'(in_weights[WEIGHT_WIDTH +: WEIGHT_WIDTH]);
  assign c2 = c1 + SW'(in_weights[2*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
  assign c3 = c2 + SW'(in_weights[3*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
  // lfsr is never 0, so r = lfsr*sum/256 always lands strictly below sum
  assign r = SW'((SW+8)'(lfsr) * (SW+8)'(c3) >> 8);
  assign out_segment_number = r < c0 ? 2'd0 : r < c1 ? 2'd1 : r < c2 ? 2'd2 : 2'd3;
  always_ff @(posedge in_clock)
    if (in_reset) lfsr <= (in_seed == 8'd0) ? 8'd1 : in_seed;
    else if (in_enable) lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
endmodule

module random_choose_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int CHOOSE_LATENCY = 2
) (
  input  logic                              in_clock,
  input  logic                              in_reset,
  input  logic [7:0]                        in_seed,
  input  logic [NUM_REQ-1:0]                in_req,
  input  logic [NUM_REQ*4*WEIGHT_WIDTH-1:0] in_weights,
  output logic [NUM_REQ-1:0]                out_grant,
  output logic                              out_busy,
  output logic                              out_valid,
  output logic [$clog2(NUM_REQ)-1:0]        out_req_id,
  output logic [1:0]                        out_segment_number,
  output logic                              out_zero_weight
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CHOOSE_LATENCY + 1);
  localparam int SW = WEIGHT_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t                    state, state_nx;
  logic [IW-1:0]             rr_ptr, pick_id;
  logic [IW:0]               idx;
  logic [4*WEIGHT_WIDTH-1:0] w_lat;
  logic [SW-1:0]             sum;
  logic [CW-1:0]             cnt;
  logic                      chooser_en, last;
  logic [1:0]                chosen;
  random_choose #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_chooser (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_seed(in_seed),
    .in_enable(chooser_en),
    .in_weights(w_lat),
    .out_segment_number(chosen)
  );
  assign sum = SW'(w_lat[0 +: WEIGHT_WIDTH]) + SW'(w_lat[WEIGHT_WIDTH +: WEIGHT_WIDTH])
             + SW'(w_lat[2*WEIGHT_WIDTH +: WEIGHT_WIDTH]) + SW'(w_lat[3*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
  assign last = cnt == CW'(CHOOSE_LATENCY - 1);
  // scan downward so the candidate closest above rr_ptr is the one left standing
  always_comb begin
    idx = '0;
    pick_id = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      pick_id = in_req[idx[IW-1:0]] ? idx[IW-1:0] : pick_id;
    end
  end
  always_comb begin
    state_nx = (state == IDLE) ? (|in_req ? LOAD : IDLE) :
               (state == LOAD) ? (sum == '0 ? DONE : RUN) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge in_clock)
    if (in_reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      rr_ptr             <= '0;
      out_grant          <= '0;
      out_busy           <= 1'b0;
      out_valid          <= 1'b0;
      out_req_id         <= '0;
      out_segment_number <= 2'd0;
      out_zero_weight    <= 1'b0;
      w_lat              <= '0;
      cnt                <= '0;
      chooser_en         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (|in_req) begin
          out_req_id      <= pick_id;
          out_grant       <= NUM_REQ'(1) << pick_id;
          out_busy        <= 1'b1;
          out_zero_weight <= 1'b0;
          w_lat           <= in_weights[pick_id*4*WEIGHT_WIDTH +: 4*WEIGHT_WIDTH];
        end
        LOAD: if (sum == '0) begin
          out_zero_weight    <= 1'b1;
          out_segment_number <= 2'd0;
          out_valid          <= 1'b1;
        end else begin
          chooser_en <= 1'b1;
          cnt        <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            out_segment_number <= chosen;
            chooser_en         <= 1'b0;
            out_valid          <= 1'b1;
          end
        end
        default: begin
          rr_ptr    <= (out_req_id == IW'(NUM_REQ - 1)) ? '0 : out_req_id + 1'b1;
          out_grant <= '0;
          out_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_random_choose_arbiter.sv
// tb_random_choose_arbiter: randomized checks of arbitration order, latency and chooser results.
module tb_random_choose_arbiter;
  localparam int NR = 4;
  localparam int L  = 2;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   seed = 8'd1;
  logic [3:0]   req = '0;
  logic [127:0] weights = '0;
  logic [3:0]   grant;
  logic         busy, valid, zw;
  logic [1:0]   req_id, seg;
  int           errors = 0;
  int           checks = 0;
  logic         watch_en = 1'b0;
  logic         en_seen = 1'b0;

  random_choose_arbiter #(.NUM_REQ(NR), .WEIGHT_WIDTH(8), .CHOOSE_LATENCY(L)) dut (
    .in_clock(clk),
    .in_reset(rst),
    .in_seed(seed),
    .in_req(req),
    .in_weights(weights),
    .out_grant(grant),
    .out_busy(busy),
    .out_valid(valid),
    .out_req_id(req_id),
    .out_segment_number(seg),
    .out_zero_weight(zw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (watch_en && dut.chooser_en) en_seen <= 1'b1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step;
      n++;
    end while (!valid && n < 40);
  endtask

  task automatic set_w(input int r, input logic [7:0] a, b, c, d);
    weights[(4*r)*8 +: 8]   = a;
    weights[(4*r+1)*8 +: 8] = b;
    weights[(4*r+2)*8 +: 8] = c;
    weights[(4*r+3)*8 +: 8] = d;
  endtask

  function automatic int get_w(input int r, input int k);
    return int'(weights[(4*r+k)*8 +: 8]);
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int rr);
    for (int i = 0; i < NR; i++)
      if (mask[(rr + i) % NR]) return (rr + i) % NR;
    return -1;
  endfunction

  task automatic do_reset(input logic [3:0] m);
    rst = 1'b1;
    req = m;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'hF;
    step;
    step;
    checks += 6;
    if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    if (req_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", req_id); end
    if (seg !== 2'd0) begin errors++; $display("FAIL reset_seg got %0d want 0", seg); end
    if (zw !== 1'b0) begin errors++; $display("FAIL reset_zw got %b want 0", zw); end
  endtask

  task automatic test_single;
    int n;
    int cnt[4];
    cnt = '{0, 0, 0, 0};
    seed = 8'd1;
    set_w(0, 8'd2, 8'd4, 8'd2, 8'd0);
    do_reset(4'b0001);
    for (int k = 0; k < 100; k++) begin
      wait_valid(n);
      checks += 3;
      if (n !== ((k == 0) ? 2 + L : 3 + L)) begin errors++; $display("FAIL single_latency svc %0d got %0d want %0d", k, n, (k == 0) ? 2 + L : 3 + L); end
      if (req_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", req_id); end
      if (zw !== 1'b0) begin errors++; $display("FAIL single_zw got %b want 0", zw); end
      cnt[seg]++;
      if (k == 99) req = 4'b0;
    end
    checks += 3;
    if (cnt[3] != 0) begin errors++; $display("FAIL single_seg3 got %0d want 0", cnt[3]); end
    if (!(cnt[1] > cnt[0] && cnt[1] < 4 * cnt[0])) begin errors++; $display("FAIL single_ratio10 got %0d:%0d want about 2:1", cnt[1], cnt[0]); end
    if (!(cnt[1] > cnt[2] && cnt[1] < 4 * cnt[2])) begin errors++; $display("FAIL single_ratio12 got %0d:%0d want about 2:1", cnt[1], cnt[2]); end
  endtask

  task automatic test_zero;
    set_w(2, 8'd0, 8'd0, 8'd0, 8'd0);
    req = 4'b0100;
    en_seen = 1'b0;
    watch_en = 1'b1;
    step;
    step;
    checks += 3;
    if (grant !== 4'b0100) begin errors++; $display("FAIL zero_grant got %b want 0100", grant); end
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL zero_early_valid got %b want 0", valid); end
    step;
    req = 4'b0;
    checks += 4;
    if (valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", valid); end
    if (zw !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", zw); end
    if (seg !== 2'd0) begin errors++; $display("FAIL zero_seg got %0d want 0", seg); end
    if (req_id !== 2'd2) begin errors++; $display("FAIL zero_id got %0d want 2", req_id); end
    step;
    watch_en = 1'b0;
    checks += 3;
    if (valid !== 1'b0) begin errors++; $display("FAIL zero_pulse got %b want 0", valid); end
    if (grant !== 4'b0) begin errors++; $display("FAIL zero_idle_grant got %b want 0000", grant); end
    if (en_seen !== 1'b0) begin errors++; $display("FAIL zero_enable got %b want 0", en_seen); end
  endtask

  task automatic test_round_robin;
    int rr = 0;
    int exp_id, n, want;
    logic [3:0] mask = 4'hF;
    bit exp_zero;
    for (int r = 0; r < NR; r++) set_w(r, 8'(r + 1), 8'd3, 8'd0, 8'd7);
    seed = 8'h5A;
    do_reset(mask);
    for (int s = 0; s < 24; s++) begin
      exp_id = rr_pick(mask, rr);
      exp_zero = (get_w(exp_id, 0) + get_w(exp_id, 1) + get_w(exp_id, 2) + get_w(exp_id, 3)) == 0;
      want = (s == 0 ? 2 : 3) + (exp_zero ? 0 : L);
      n = 0;
      do begin
        step;
        n++;
        if (busy) begin
          checks++;
          if (grant !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant svc %0d got %b want %b", s, grant, 4'(1 << exp_id)); end
        end
      end while (!valid && n < 40);
      checks += 3;
      if (n !== want) begin errors++; $display("FAIL rr_latency svc %0d got %0d want %0d", s, n, want); end
      if (req_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_id svc %0d got %0d want %0d", s, req_id, exp_id); end
      if (zw !== exp_zero) begin errors++; $display("FAIL rr_zw svc %0d got %b want %b", s, zw, exp_zero); end
      if (!exp_zero) begin
        checks++;
        if (get_w(exp_id, int'(seg)) == 0) begin errors++; $display("FAIL rr_seg svc %0d got seg %0d with zero weight", s, seg); end
      end
      rr = (exp_id + 1) % NR;
      if (s >= 7) begin
        mask = 4'($urandom_range(1, 15));
        for (int r = 0; r < NR; r++)
          if ($urandom_range(0, 3) == 0) set_w(r, 8'd0, 8'd0, 8'd0, 8'd0);
          else set_w(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        req = mask;
      end
    end
    req = 4'b0;
    step;
  endtask

  task automatic test_weight_latch;
    int n;
    set_w(1, 8'd0, 8'd0, 8'd5, 8'd0);
    do_reset(4'b0010);
    step;
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL latch_grant got %b want 0010", grant); end
    set_w(1, 8'd5, 8'd0, 8'd0, 8'd0);
    req = 4'b0;
    wait_valid(n);
    checks += 3;
    if (n !== 1 + L) begin errors++; $display("FAIL latch_latency got %0d want %0d", n, 1 + L); end
    if (seg !== 2'd2) begin errors++; $display("FAIL latch_seg got %0d want 2", seg); end
    if (req_id !== 2'd1) begin errors++; $display("FAIL latch_id got %0d want 1", req_id); end
    step;
  endtask

  task automatic test_reset_mid;
    int n;
    set_w(3, 8'd1, 8'd1, 8'd1, 8'd1);
    set_w(0, 8'd1, 8'd2, 8'd3, 8'd4);
    do_reset(4'b1000);
    step;
    step;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
    rst = 1'b1;
    req = 4'b1001;
    step;
    checks += 6;
    if (grant !== 4'b0) begin errors++; $display("FAIL mid_rst_grant got %b want 0000", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid); end
    if (req_id !== 2'd0) begin errors++; $display("FAIL mid_rst_id got %0d want 0", req_id); end
    if (seg !== 2'd0) begin errors++; $display("FAIL mid_rst_seg got %0d want 0", seg); end
    if (zw !== 1'b0) begin errors++; $display("FAIL mid_rst_zw got %b want 0", zw); end
    rst = 1'b0;
    step;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL mid_after_grant got %b want 0001", grant); end
    wait_valid(n);
    req = 4'b0;
    checks += 2;
    if (n !== 1 + L) begin errors++; $display("FAIL mid_after_latency got %0d want %0d", n, 1 + L); end
    if (req_id !== 2'd0) begin errors++; $display("FAIL mid_after_id got %0d want 0", req_id); end
    step;
  endtask

  task automatic test_single_segment;
    int n;
    set_w(0, 8'd0, 8'd0, 8'd0, 8'd255);
    seed = 8'hC3;
    do_reset(4'b0001);
    for (int k = 0; k < 40; k++) begin
      wait_valid(n);
      checks += 3;
      if (n !== ((k == 0) ? 2 + L : 3 + L)) begin errors++; $display("FAIL seg_latency svc %0d got %0d want %0d", k, n, (k == 0) ? 2 + L : 3 + L); end
      if (zw !== 1'b0) begin errors++; $display("FAIL seg_zw svc %0d got %b want 0", k, zw); end
      if (k < 20) begin
        checks++;
        if (seg !== 2'd3) begin errors++; $display("FAIL seg_only3 svc %0d got %0d want 3", k, seg); end
      end
      if (k == 19) set_w(0, 8'd255, 8'd255, 8'd255, 8'd255);
      if (k == 39) req = 4'b0;
    end
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_zero;
    test_round_robin;
    test_weight_latch;
    test_reset_mid;
    test_single_segment;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
